// File: rtl/fa_mon_pkg.sv
// Package: fa_mon_pkg
// Purpose: shared definitions for the full-adder response monitor.
//   - fa_state_e  : monitor FSM encoding (IDLE, RUN, DONE)
//   - NUM_VECTORS : number of distinct {a,b,c} input combinations
//   - fa_golden   : reference full-adder function, returns {sum, carry}
package fa_mon_pkg;

    localparam int NUM_VECTORS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fa_state_e;

    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

endpackage

// File: rtl/full_adder_monitor_if.sv
// Interface: full_adder_monitor_if
// Purpose: groups the stimulus/response signals of the adder under test and
//          the result signals of the monitor.
// Signals:
//   en          monitor enable (1 = running, 0 = idle with results held)
//   a, b, c     stimulus applied to the adder under test
//   sum, carry  adder under test outputs
//   check_valid 1-cycle pulse: a vector was checked
//   mismatch    1-cycle pulse alongside check_valid when sum/carry were wrong
//   err_cnt     saturating mismatch count
//   cov_map     bit i set once vector {a,b,c}==i has been checked
//   done, pass  full coverage reached / full coverage with no errors
//   first_fail  {a,b,c,sum,carry} of the first mismatch (zero unless logging built)
//   state_dbg   current monitor FSM state (fa_state_e encoding)
// Modports: master drives stimulus and observes results; slave is the monitor.
//
// Handshake: there is no backpressure anywhere. check_valid is a qualifier that
// is high for exactly one cycle per checked vector; mismatch is only meaningful
// while check_valid is high. All other outputs are level signals.
interface full_adder_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 sum;
    logic                 carry;
    logic                 check_valid;
    logic                 mismatch;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [7:0]           cov_map;
    logic                 done;
    logic                 pass;
    logic [4:0]           first_fail;
    logic [1:0]           state_dbg;

    modport master (
        output en, a, b, c, sum, carry,
        input  check_valid, mismatch, err_cnt, cov_map, done, pass, first_fail, state_dbg
    );

    modport slave (
        input  en, a, b, c, sum, carry,
        output check_valid, mismatch, err_cnt, cov_map, done, pass, first_fail, state_dbg
    );
endinterface

// File: rtl/fa_mon_stable_det.sv
// Module: fa_mon_stable_det
// Purpose: decides when the adder input vector has been stable long enough to
//          be sampled. Holds the previous-vector register, a stable-cycle counter
//          saturating at HOLD_CYCLES, and a flag that limits sampling to once
//          per stable interval.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   run       monitor is in RUN with en high; state only advances while set
//   clear     entering RUN: restart stability tracking from the current vector
//   vec       current {a,b,c}
//   strobe    combinational: sample this cycle (registered by the top)
module fa_mon_stable_det
    import fa_mon_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic                           clear,
    input  logic [$clog2(NUM_VECTORS)-1:0] vec,
    output logic                           strobe
);
    localparam logic [7:0] HOLD    = 8'(HOLD_CYCLES);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    logic [$clog2(NUM_VECTORS)-1:0] prev;
    logic [7:0]                     cnt;
    logic                           checked;
    logic                           changed;

    assign changed = (vec != prev);
    // A change on the cycle the sample would fire suppresses it.
    assign strobe  = run && !changed && !checked && (cnt == HOLD_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            cnt     <= '0;
            checked <= 1'b0;
        end else if (clear) begin
            // Entry into RUN behaves like a fresh input change.
            prev    <= vec;
            cnt     <= '0;
            checked <= 1'b0;
        end else if (run) begin
            prev <= vec;
            if (changed) begin
                cnt     <= '0;
                checked <= 1'b0;
            end else begin
                if (cnt != HOLD) cnt <= cnt + 8'd1;
                if (strobe) checked <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/full_adder_monitor.sv
// Module: full_adder_monitor
// Purpose: synchronous response checker for a 1-bit full adder. Each input
//          vector held stable for HOLD_CYCLES is checked once against the golden
//          function; mismatches are counted (saturating), coverage of the 8
//          vectors is tracked, and done/pass are raised on full coverage.
// Parameters:
//   HOLD_CYCLES  stable cycles required before sampling (1..255)
//   ERR_CNT_W    mismatch counter width
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       full_adder_monitor_if.slave (stimulus, adder outputs, results)
// Build option: define FA_MON_LOG_EN to capture {a,b,c,sum,carry} of the first
//   mismatch after entering RUN on bus.first_fail; otherwise it is tied to 0.
module full_adder_monitor
    import fa_mon_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    full_adder_monitor_if.slave         bus
);
    localparam logic [1:0]             S_IDLE  = ST_IDLE;
    localparam logic [1:0]             S_RUN   = ST_RUN;
    localparam logic [1:0]             S_DONE  = ST_DONE;
    localparam logic [ERR_CNT_W-1:0]   ERR_MAX = '1;
    localparam logic [NUM_VECTORS-1:0] COV_ALL = '1;

    logic [1:0]             state;
    logic                   check_valid_q;
    logic                   mismatch_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [NUM_VECTORS-1:0] cov_map_q;
    logic                   done_q;
    logic                   pass_q;

    logic [2:0] vec;
    logic [1:0] golden;
    logic       run;
    logic       enter;
    logic       strobe;
    logic       bad;

    assign vec    = {bus.a, bus.b, bus.c};
    assign golden = fa_golden(bus.a, bus.b, bus.c);
    assign run    = (state == S_RUN) && bus.en;
    assign enter  = (state == S_IDLE) && bus.en;
    assign bad    = strobe && ({bus.sum, bus.carry} != golden);

    fa_mon_stable_det #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_stable (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clear  (enter),
        .vec    (vec),
        .strobe (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            check_valid_q <= 1'b0;
            mismatch_q    <= 1'b0;
            err_cnt_q     <= '0;
            cov_map_q     <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            check_valid_q <= strobe;
            mismatch_q    <= bad;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state     <= S_RUN;
                        err_cnt_q <= '0;
                        cov_map_q <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!bus.en) begin
                        state <= S_IDLE;
                    end else begin
                        if (strobe) cov_map_q[vec] <= 1'b1;
                        if (bad && (err_cnt_q != ERR_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
                        // Coverage completed by the previous cycle's check.
                        if (cov_map_q == COV_ALL) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            pass_q <= (err_cnt_q == '0);
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.en) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FA_MON_LOG_EN
    logic       log_valid;
    logic [4:0] first_fail_q;

    always_ff @(posedge clk) begin
        if (rst || enter) begin
            log_valid    <= 1'b0;
            first_fail_q <= '0;
        end else if (bad && !log_valid) begin
            log_valid    <= 1'b1;
            first_fail_q <= {vec, bus.sum, bus.carry};
        end
    end

    assign bus.first_fail = first_fail_q;
`else
    assign bus.first_fail = 5'b0;
`endif

    assign bus.check_valid = check_valid_q;
    assign bus.mismatch    = mismatch_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.cov_map     = cov_map_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_full_adder_monitor.sv
// Bench for full_adder_monitor. A second instance with a 2-bit error counter
// watches an adder whose sum is always inverted, to exercise saturation.
module tb_full_adder_monitor;
    localparam int HOLD = 4;

`ifdef FA_MON_LOG_EN
    localparam logic [4:0] EXP_FIRST_FAIL = 5'b01100;
`else
    localparam logic [4:0] EXP_FIRST_FAIL = 5'b00000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and adder models ----------------
    full_adder_monitor_if #(.ERR_CNT_W(8)) bus ();
    full_adder_monitor_if #(.ERR_CNT_W(2)) bus2 ();

    full_adder_monitor #(.HOLD_CYCLES(HOLD), .ERR_CNT_W(8)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    full_adder_monitor #(.HOLD_CYCLES(HOLD), .ERR_CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    // fault: 0 = correct adder, 1 = carry stuck-at-0, 2 = sum inverted
    logic [1:0] fault = 2'd0;
    logic       maj;
    assign maj       = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
    assign bus.sum   = (bus.a ^ bus.b ^ bus.c) ^ (fault == 2'd2);
    assign bus.carry = (fault == 2'd1) ? 1'b0 : maj;

    assign bus2.en    = bus.en;
    assign bus2.a     = bus.a;
    assign bus2.b     = bus.b;
    assign bus2.c     = bus.c;
    assign bus2.sum   = ~(bus.a ^ bus.b ^ bus.c);
    assign bus2.carry = maj;

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int chk_pulses = 0;
    int mm_pulses = 0;
    int last_chk_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected mismatch for vector v given the active fault, from bit counts.
    function automatic logic exp_mm(input logic [2:0] v, input logic [1:0] f);
        int ones;
        ones = $countones(v);
        if (f == 2'd1) return (ones >= 2);
        if (f == 2'd2) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (bus.check_valid) begin
            chk_pulses++;
            last_chk_cyc = cyc;
            check("check_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("mismatch", 32'(bus.mismatch), 32'(exp_q.pop_front()));
        end
        if (bus.mismatch) mm_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold vector v for 'hold' edges; a check is due only if held past HOLD.
    task automatic apply(input logic [2:0] v, input int hold);
        {bus.a, bus.b, bus.c} = v;
        if (hold > HOLD) exp_q.push_back(exp_mm(v, fault));
        step(hold);
    endtask

    task automatic sweep();
        for (int v = 0; v < 8; v++) apply(3'(v), 6);
        step(2);
    endtask

    task automatic leave_run();
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0, m0, t0;
        bus.en = 1'b0;
        {bus.a, bus.b, bus.c} = 3'b000;

        // Reset state
        step(3);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);
        check("rst_cov", 32'(bus.cov_map), 32'd0);
        check("rst_done_pass", 32'({bus.done, bus.pass, bus.check_valid, bus.mismatch}), 32'd0);
        rst = 1'b0;

        // 1: correct adder, full sweep
        c0 = chk_pulses; m0 = mm_pulses;
        bus.en = 1'b1;
        sweep();
        check("t1_checks", 32'(chk_pulses - c0), 32'd8);
        check("t1_mismatches", 32'(mm_pulses - m0), 32'd0);
        check("t1_cov", 32'(bus.cov_map), 32'hFF);
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_pass", 32'(bus.pass), 32'd1);
        check("t1_err", 32'(bus.err_cnt), 32'd0);
        check("t1_state", 32'(bus.state_dbg), 32'd2);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        // 5: inverted sum into 2-bit counter saturates at 3
        check("t5_err_sat", 32'(bus2.err_cnt), 32'd3);
        check("t5_pass", 32'({bus2.done, bus2.pass}), 32'b10);

        // Results hold in IDLE
        bus.en = 1'b0;
        step(1);
        check("idle_state", 32'(bus.state_dbg), 32'd0);
        check("idle_hold", 32'({bus.done, bus.pass, bus.cov_map}), 32'h3FF);

        // 2: carry stuck-at-0
        fault = 2'd1;
        c0 = chk_pulses; m0 = mm_pulses;
        bus.en = 1'b1;
        sweep();
        check("t2_mismatches", 32'(mm_pulses - m0), 32'd4);
        check("t2_err", 32'(bus.err_cnt), 32'd4);
        check("t2_done_pass", 32'({bus.done, bus.pass}), 32'b10);
        check("t2_first_fail", 32'(bus.first_fail), 32'(EXP_FIRST_FAIL));

        // 3: vector 5 held too briefly
        fault = 2'd0;
        leave_run();
        for (int v = 0; v < 5; v++) apply(3'(v), 6);
        apply(3'd5, 2);
        apply(3'd6, 6);
        apply(3'd7, 6);
        step(2);
        check("t3_cov", 32'(bus.cov_map), 32'hDF);
        check("t3_done", 32'(bus.done), 32'd0);
        check("t3_state", 32'(bus.state_dbg), 32'd1);
        check("t3_err_cleared", 32'(bus.err_cnt), 32'd0);

        // 4: long hold, one check, latency HOLD edges after the change edge
        c0 = chk_pulses;
        t0 = cyc;
        apply(3'd5, 50);
        check("t4_one_check", 32'(chk_pulses - c0), 32'd1);
        check("t4_latency", 32'(last_chk_cyc - t0), 32'(1 + HOLD));
        check("t4_done_pass", 32'({bus.done, bus.pass}), 32'b11);

        // 6: reset mid-sweep after three checks
        fault = 2'd2;
        leave_run();
        c0 = chk_pulses;
        for (int v = 0; v < 3; v++) apply(3'(v), 6);
        check("t6_three_checks", 32'(chk_pulses - c0), 32'd3);
        check("t6_err_pre", 32'(bus.err_cnt), 32'd3);
        apply(3'd3, 2);
        rst = 1'b1;
        step(1);
        exp_q.delete();
        check("t6_rst_state", 32'(bus.state_dbg), 32'd0);
        check("t6_rst_outs", 32'({bus.check_valid, bus.mismatch, bus.done, bus.pass, bus.first_fail}), 32'd0);
        check("t6_rst_err_cov", 32'({bus.err_cnt, bus.cov_map}), 32'd0);
        rst = 1'b0;
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
        step(1);
        check("t6_restart_cov", 32'(bus.cov_map), 32'd0);
        check("t6_restart_state", 32'(bus.state_dbg), 32'd1);
        apply(3'd7, 6);
        check("t6_cov_one", 32'(bus.cov_map), 32'h80);
        check("t6_err_one", 32'(bus.err_cnt), 32'd1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
